// File: rtl/aes_pkg.sv
// Shared types for the AES-128 round sequencer.
// FSM states, stage selects and block width.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_BLOCK_W    = 128;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_ARK,
    S_SB,
    S_SR,
    S_MC,
    S_FIN
  } aes_state_e;

  typedef enum logic [1:0] {
    SEL_ARK,
    SEL_SB,
    SEL_SR,
    SEL_MC
  } stage_sel_e;

  function automatic logic is_stage(
    input aes_state_e s
  );
    return s inside {S_ARK, S_SB, S_SR, S_MC};
  endfunction

  function automatic stage_sel_e stage_of(
    input aes_state_e s
  );
    case (s)
      S_SB:    return SEL_SB;
      S_SR:    return SEL_SR;
      S_MC:    return SEL_MC;
      default: return SEL_ARK;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Stage and round-key bus between the sequencer
// and the AddRoundKey/SubBytes/ShiftRows/MixColumns units.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  block_t stage_in;
  logic   ark_en;
  logic   sb_en;
  logic   sr_en;
  logic   mc_en;
  logic   ark_done;
  logic   sb_done;
  logic   sr_done;
  logic   mc_done;
  block_t ark_out;
  block_t sb_out;
  block_t sr_out;
  block_t mc_out;
  logic   key_req;
  logic   key_valid;

  modport master (
    output stage_in,
    output ark_en, sb_en, sr_en, mc_en,
    output key_req,
    input  ark_done, sb_done, sr_done, mc_done,
    input  ark_out, sb_out, sr_out, mc_out,
    input  key_valid
  );

  modport slave (
    input  stage_in,
    input  ark_en, sb_en, sr_en, mc_en,
    input  key_req,
    output ark_done, sb_done, sr_done, mc_done,
    output ark_out, sb_out, sr_out, mc_out,
    output key_valid
  );

endinterface

// File: rtl/aes_ctrl_watchdog.sv
// Stage watchdog: loaded on a stage enable, counts
// down while waiting, flags expiry on the last cycle.
module aes_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(TIMEOUT_CYCLES - 1);
    end else if (run && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = run && (cnt_q == W'(1));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer and state register.
// Optional stage watchdog: define AES_CTRL_TIMEOUT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  block_t     plaintext,
  output logic       busy,
  output logic       done,
  output block_t     ciphertext,
  output logic [3:0] round_num,
`ifdef AES_CTRL_TIMEOUT_EN
  output logic       err,
`endif
  aes_round_ctrl_if.master bus
);

  localparam logic [3:0] LAST = 4'(AES_NUM_ROUNDS);

  aes_state_e state_q, state_d;
  logic [3:0] round_q, round_d;
  block_t     data_q, data_d;
  logic       first_q, first_d;
  stage_sel_e sel;
  logic       stg_done;
  block_t     stg_out;
  logic       abort;

  assign sel = stage_of(state_q);

  always_comb begin
    stg_done = 1'b0;
    stg_out  = bus.ark_out;
    unique case (sel)
      SEL_ARK: begin
        stg_done = bus.ark_done;
        stg_out  = bus.ark_out;
      end
      SEL_SB: begin
        stg_done = bus.sb_done;
        stg_out  = bus.sb_out;
      end
      SEL_SR: begin
        stg_done = bus.sr_done;
        stg_out  = bus.sr_out;
      end
      SEL_MC: begin
        stg_done = bus.mc_done;
        stg_out  = bus.mc_out;
      end
    endcase
  end

  // first_q is only ever set in a stage state
  assign bus.ark_en = first_q && sel == SEL_ARK;
  assign bus.sb_en  = first_q && sel == SEL_SB;
  assign bus.sr_en  = first_q && sel == SEL_SR;
  assign bus.mc_en  = first_q && sel == SEL_MC;

  assign bus.stage_in = data_q;
  assign ciphertext   = data_q;
  assign round_num    = round_q;

`ifdef AES_CTRL_TIMEOUT_EN
  logic wd_exp;
  logic err_q;

  aes_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .load    (first_q),
    .run     (is_stage(state_q) && !first_q),
    .expired (wd_exp)
  );

  // a done on the final watchdog cycle still wins
  assign abort = wd_exp && !stg_done;
  assign err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    data_d      = data_q;
    busy        = 1'b1;
    done        = 1'b0;
    bus.key_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          data_d  = plaintext;
          round_d = '0;
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        bus.key_req = 1'b1;
        if (bus.key_valid) state_d = S_ARK;
      end
      S_ARK, S_SB, S_SR, S_MC: begin
        if (!first_q && stg_done) begin
          data_d = stg_out;
          case (state_q)
            S_ARK: begin
              if (round_q == LAST) begin
                state_d = S_FIN;
              end else begin
                round_d = round_q + 4'd1;
                state_d = S_SB;
              end
            end
            S_SB:    state_d = S_SR;
            S_SR:    state_d = (round_q < LAST) ? S_MC : S_KEY;
            default: state_d = S_KEY;
          endcase
        end
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
    first_d = is_stage(state_d) && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl with
// behavioural AES stage models and a result scoreboard.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  block_t     plaintext;
  logic       busy;
  logic       done;
  block_t     ciphertext;
  logic [3:0] round_num;
`ifdef AES_CTRL_TIMEOUT_EN
  logic       err;
`endif

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext),
    .round_num  (round_num),
`ifdef AES_CTRL_TIMEOUT_EN
    .err        (err),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  block_t sb_q[$];

  logic [7:0]  sbox [256];
  block_t      rk   [11];
  logic        key_valid;
  logic        inj_mc;
  logic        sup_sb;

  logic   ark_d, sb_d, sr_d, mc_d;
  block_t ark_o, sb_o, sr_o, mc_o;

  assign bus.key_valid = key_valid;
  assign bus.ark_done  = ark_d;
  assign bus.sb_done   = sb_d;
  assign bus.sr_done   = sr_d;
  assign bus.mc_done   = mc_d | inj_mc;
  assign bus.ark_out   = ark_o;
  assign bus.sb_out    = sb_o;
  assign bus.sr_out    = sr_o;
  assign bus.mc_out    = mc_o;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic block_t sub_bytes(input block_t b);
    block_t o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox[b[127-8*i -: 8]];
    return o;
  endfunction

  function automatic block_t shift_rows(input block_t b);
    block_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] =
          b[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic block_t mix_cols(input block_t b);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic block_t aes_ref(input block_t pt);
    block_t s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++)
      s = mix_cols(shift_rows(sub_bytes(s))) ^ rk[r];
    return shift_rows(sub_bytes(s)) ^ rk[10];
  endfunction

  task automatic build_tables(input block_t key);
    logic [7:0]  inv, t, s, rc;
    logic [31:0] w [44];
    logic [31:0] tw;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      t = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        t = rl1(t);
        s = s ^ t;
      end
      sbox[x] = s ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox[tw[31:24]], sbox[tw[23:16]],
              sbox[tw[15:8]],  sbox[tw[7:0]]};
        tw = tw ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // one-cycle stage models
  always @(posedge clk) begin
    ark_d <= bus.ark_en;
    sb_d  <= bus.sb_en && !(sup_sb && round_num == 4'd2);
    sr_d  <= bus.sr_en;
    mc_d  <= bus.mc_en;
    if (bus.ark_en) ark_o <= bus.stage_in ^ rk[round_num];
    if (bus.sb_en)  sb_o  <= sub_bytes(bus.stage_in);
    if (bus.sr_en)  sr_o  <= shift_rows(bus.stage_in);
    if (bus.mc_en)  mc_o  <= mix_cols(bus.stage_in);
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ens();
    return {bus.ark_en, bus.sb_en, bus.sr_en, bus.mc_en};
  endfunction

  task automatic run_block(
    input block_t pt,
    input block_t exp,
    input int     st_rnd,
    input int     st_len,
    input bit     spur,
    input int     exp_lat
  );
    int lat, n_ark, n_mc, n_r10, n_stall, left;
    bit seen, prev_sb;
    block_t want;
    lat = 0; n_ark = 0; n_mc = 0; n_r10 = 0;
    n_stall = 0; left = st_len;
    seen = 0; prev_sb = 0;
    start = 1'b1;
    plaintext = pt;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    plaintext = ~pt;
    chk("busy_after_start", busy, 1);
    chk("key_req_round0", bus.key_req, 1);
    chk("round_after_start", round_num, 0);
    while (!seen && lat < 400) begin
      @(posedge clk); lat++; #1;
      if (bus.ark_en) n_ark++;
      if (bus.mc_en) begin
        n_mc++;
        if (round_num == 4'd10) n_r10++;
      end
      if (!key_valid &&
          !(bus.key_req && int'(round_num) == st_rnd
            && ens() == 4'b0))
        n_stall++;
      if (done) seen = 1;
      if (bus.key_req && int'(round_num) == st_rnd
          && left > 0) begin
        key_valid = 1'b0;
        left--;
      end else begin
        key_valid = 1'b1;
      end
      inj_mc  = spur && (bus.sb_en || prev_sb);
      prev_sb = bus.sb_en;
      if (spur) start = (lat == 20);
    end
    start = 1'b0;
    inj_mc = 1'b0;
    key_valid = 1'b1;
    want = sb_q.pop_front();
    chk("done_seen", seen, 1);
    chk("latency", lat, exp_lat);
    chk("ciphertext", ciphertext, want);
    chk("busy_at_done", busy, 0);
    chk("ark_en_pulses", n_ark, 11);
    chk("mc_en_pulses", n_mc, 9);
    chk("mc_en_in_round10", n_r10, 0);
    chk("key_stall_hold", n_stall, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("ciphertext_held", ciphertext, want);
  endtask

  localparam block_t FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    block_t p;
    int nd;
`ifdef AES_CTRL_TIMEOUT_EN
    int lat;
`endif
    reset = 1'b0;
    start = 1'b0;
    plaintext = '0;
    key_valid = 1'b1;
    inj_mc = 1'b0;
    sup_sb = 1'b0;
    build_tables(FIPS_KEY);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ciphertext", ciphertext, 0);
    chk("rst_round", round_num, 0);
    chk("rst_key_req", bus.key_req, 0);
    chk("rst_stage_in", bus.stage_in, 0);
    chk("rst_enables", ens(), 0);
`ifdef AES_CTRL_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    run_block(FIPS_PT, FIPS_CT, -1, 0, 0, 91);

    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(p, aes_ref(p), 4, 5, 0, 96);

    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(p, aes_ref(p), -1, 0, 1, 91);

    // abort mid-block
    p = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    plaintext = p;
    sb_q.push_back(aes_ref(p));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ciphertext", ciphertext, 0);
    chk("abort_round", round_num, 0);
    chk("abort_key_req", bus.key_req, 0);
    chk("abort_enables", ens(), 0);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b1;
    nd = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_abort", nd, 0);

    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(p, aes_ref(p), -1, 0, 0, 91);

`ifdef AES_CTRL_TIMEOUT_EN
    sup_sb = 1'b1;
    start = 1'b1;
    plaintext = p;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!(bus.sb_en && round_num == 4'd2)
           && lat < 200) begin
      @(posedge clk); lat++; #1;
    end
    chk("sb_en_round2", bus.sb_en && round_num == 4'd2, 1);
    repeat (15) @(posedge clk);
    #1;
    chk("err_before_timeout", err, 0);
    @(posedge clk); #1;
    chk("err_at_timeout", err, 1);
    chk("busy_at_timeout", busy, 0);
    nd = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_timeout", nd, 0);
    chk("err_sticky", err, 1);
    sup_sb = 1'b0;
    p = {$urandom, $urandom, $urandom, $urandom};
    run_block(p, aes_ref(p), -1, 0, 0, 91);
    chk("err_cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the AES-128 encryption datapath. It owns the 128-bit cipher state register and drives the AddRoundKey, SubBytes, ShiftRows and MixColumns stage modules through all 11 key additions and 10 rounds. Each stage module is started with a one-cycle enable pulse and finishes with a registered `done`. The controller also requests round keys from key expansion over a valid handshake, and presents start/busy/done to the top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum cycles to wait for a stage `done` (used only with the watchdog compiled in).

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: begin encryption of `plaintext`; sampled only in IDLE.
- `plaintext` input 128: block loaded into the state register on accepted `start`.
- `busy` output 1: high from accepted `start` until the cycle `done` is asserted.
- `done` output 1: one-cycle pulse; `ciphertext` is valid from this cycle until the next accepted `start`.
- `ciphertext` output 128: the state register.
- `round_num` output 4: current round, 0..10.
- `key_req` output 1: requesting the round key for `round_num`.
- `key_valid` input 1: the round key for `round_num` is present on the AddRoundKey key bus.
- `stage_in` output 128: the state register, fanned out to all stages.
- `ark_en`, `sb_en`, `sr_en`, `mc_en` outputs 1 each: one-cycle stage start pulses.
- `ark_done`, `sb_done`, `sr_done`, `mc_done` inputs 1 each: stage completion.
- `ark_out`, `sb_out`, `sr_out`, `mc_out` inputs 128 each: stage results.
- `err` output 1: stage timeout (present only with `AES_CTRL_TIMEOUT_EN`).

## Operation
- FSM states: IDLE, KEY, ARK, SB, SR, MC, FIN.
- IDLE: on `start`, load `plaintext`, clear `round_num` to 0, go to KEY.
- KEY: hold `key_req` high. On `key_valid`, go to ARK.
- ARK/SB/SR/MC: pulse the stage enable on the first cycle in the state only. Wait for the matching `done`. On that `done`, write the stage output into the state register and advance.
- Sequence after ARK:
  - If `round_num`==10, go to FIN.
  - Otherwise increment `round_num` and go to SB.
- Sequence after SB and SR:
  - SB goes to SR.
  - SR goes to MC if `round_num`<10, else to KEY (round 10 has no MixColumns).
  - MC goes to KEY.
- FIN: assert `done` for one cycle, then go to IDLE.
- Ignored inputs:
  - `done` inputs from non-selected stages.
  - `done` inputs arriving in the enable-pulse cycle.
  - `start` outside IDLE.
- `key_valid` low stalls KEY indefinitely; no other state is affected.
- Reset values: all outputs 0, state register 0, FSM in IDLE. Asserting reset mid-operation aborts immediately. No `done` follows the abort.

## Timing
- Each stage occupies at least 2 cycles: the enable cycle plus the wait for `done`. A stage that responds 1 cycle after enable gives exactly 2 cycles.
- Each KEY visit takes 1 cycle when `key_valid` is already high.
- With 1-cycle stages and `key_valid` tied high:
  - round 0: 3 cycles; rounds 1–9: 9 cycles each; round 10: 7 cycles.
  - `done` rises 91 cycles after the edge that samples `start`.
  - `start` may be re-accepted on the cycle after `done`.
- `round_num` updates on the edge leaving ARK and stays stable for the whole round.

## Configuration
- `AES_CTRL_TIMEOUT_EN` defined:
  - A per-stage watchdog counts cycles after each enable.
  - If no `done` arrives within `TIMEOUT_CYCLES`, `err` is set sticky, FSM returns to IDLE, `busy` drops, and no `done` is issued.
  - `err` clears on the next accepted `start`.
- Undefined: no counter and no `err` port. The controller waits indefinitely.

## Structure
- Shared `aes_pkg`:
  - FSM state enum.
  - `AES_NUM_ROUNDS`=10.
  - `AES_BLOCK_W`=128.
  - Stage-select encoding.
- One sub-module, `aes_ctrl_watchdog`: load/count/expire counter. Instantiated only under the macro.

## Test plan
- FIPS-197 Appendix B, with behavioural stage models and `key_valid` high:
  - plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32; `done` exactly 91 cycles after `start`.
- Key stall: hold `key_valid` low 5 cycles in round 4 → `round_num` holds 4, no stage enables, `done` at cycle 96.
- Spurious inputs: `start` pulsed while busy, and `mc_done` pulsed during SB → ignored; result and latency unchanged.
- Reset abort: reset at cycle 40 → all outputs 0 within the same cycle. A new `start` then completes normally.
- Round 10 check: no `mc_en` pulse occurs while `round_num`==10. Exactly 9 `mc_en` pulses and 11 `ark_en` pulses per block.
- With `AES_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: suppress `sb_done` in round 2 → `err` set 16 cycles after `sb_en`, FSM in IDLE, no `done`. The next `start` clears `err`.
